// File: rtl/boot_copier.sv
// ============================================================================
// boot_copier -- copies the boot ROM image into RAM, then releases the CPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module boot_copier #(
  parameter int unsigned WORDS  = 128,
  parameter int unsigned ADDR_W = 7,
  parameter logic [31:0] BASE   = 32'h0000_2000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic              ram_req_o,
  input  logic              ram_gnt_i,
  output logic              ram_we_o,
  output logic [3:0]        ram_be_o,
  output logic [31:0]       ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic              restart_i,
  output logic              cpu_rst_o,
  output logic              done_o,
  output logic [31:0]       checksum_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic [31:0]       csum_q, csum_d;
  logic [31:0]       word_addr;

  assign word_addr = BASE + (32'(idx_q) << 2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      idx_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      csum_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      csum_q    <= csum_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    req_d     = req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    csum_d    = csum_q;
    case (state_q)
      FETCH: begin
        wdata_d = rom_data_i;
        addr_d  = word_addr;
        req_d   = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        // Request, address and data stay frozen until the grant arrives.
        if (req_q && ram_gnt_i) begin
          req_d  = 1'b0;
          csum_d = csum_q ^ wdata_q;
          if (idx_q == LAST_IDX) begin
            state_d   = DONE;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        if (restart_i) begin
          state_d   = FETCH;
          idx_d     = '0;
          csum_d    = '0;
          cpu_rst_d = 1'b1;
          done_d    = 1'b0;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign rom_addr_o  = idx_q;
  assign ram_req_o   = req_q;
  assign ram_we_o    = req_q;
  assign ram_be_o    = 4'hF;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign cpu_rst_o   = cpu_rst_q;
  assign done_o      = done_q;
  assign checksum_o  = csum_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_copier.sv
// Directed testbench for boot_copier: default 128-word build plus a WORDS=1 build.
`default_nettype none

module tb_boot_copier;

  logic        clk = 1'b0;
  logic        rst, gnt, restart;
  logic [6:0]  rom_addr;
  logic [31:0] rom_data;
  logic        req, we, cpu_rst, done;
  logic [3:0]  be;
  logic [31:0] addr, wdata, csum;

  logic        rst1, gnt1, restart1;
  logic [6:0]  rom_addr1;
  logic [31:0] rom_data1;
  logic        req1, we1, cpu_rst1, done1;
  logic [3:0]  be1;
  logic [31:0] addr1, wdata1, csum1;

  logic [31:0] rom [128];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_data  = rom[rom_addr];
  assign rom_data1 = (rom_addr1 == 7'd0) ? 32'h0001_0067 : 32'h0;

  boot_copier u_dut (
    .clk_i(clk), .rst_i(rst), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .ram_req_o(req), .ram_gnt_i(gnt), .ram_we_o(we), .ram_be_o(be),
    .ram_addr_o(addr), .ram_wdata_o(wdata), .restart_i(restart),
    .cpu_rst_o(cpu_rst), .done_o(done), .checksum_o(csum)
  );

  boot_copier #(.WORDS(1), .ADDR_W(7), .BASE(32'h0000_4000)) u_one (
    .clk_i(clk), .rst_i(rst1), .rom_addr_o(rom_addr1), .rom_data_i(rom_data1),
    .ram_req_o(req1), .ram_gnt_i(gnt1), .ram_we_o(we1), .ram_be_o(be1),
    .ram_addr_o(addr1), .ram_wdata_o(wdata1), .restart_i(restart1),
    .cpu_rst_o(cpu_rst1), .done_o(done1), .checksum_o(csum1)
  );

  task automatic set_rom(input logic [31:0] tag);
    for (int i = 0; i < 128; i++) rom[i] = tag | 32'(i);
  endtask

  // Runs one copy starting at the current negedge (iteration 0 = state just after
  // reset release or restart). Grant comes after `stall` waiting WRITE cycles.
  // restart_i is held high at iterations rs_at and rs_at+1 (negative = never).
  task automatic run_copy(input int stall, input logic [31:0] tag,
                          input int exp_edge, input int rs_at, input string name);
    int k = 0;
    int wcnt = 0;
    logic [31:0] exp_cs = 32'h0;
    logic [31:0] h_addr = 32'h0;
    logic [31:0] h_data = 32'h0;
    for (int i = 0; i < 128; i++) exp_cs = exp_cs ^ (tag | 32'(i));
    for (int n = 0; n <= exp_edge; n++) begin
      if (n > 0) @(negedge clk);
      restart = (rs_at >= 0) && (n == rs_at || n == rs_at + 1);
      if (n < exp_edge) begin
        checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b1) begin
          errors++;
          $display("FAIL %s early_done n=%0d: done=%b cpu_rst=%b, required done=0 cpu_rst=1",
                   name, n, done, cpu_rst);
        end
        if (req === 1'b1) begin
          checks++;
          if (wcnt == 0) begin
            if (k >= 128 || addr !== 32'h2000 + 32'(k * 4) || wdata !== (tag | 32'(k)) ||
                rom_addr !== 7'(k) || we !== 1'b1 || be !== 4'hF) begin
              errors++;
              $display("FAIL %s write k=%0d: addr=%h wdata=%h rom_addr=%0d we=%b be=%h, required addr=%h wdata=%h",
                       name, k, addr, wdata, rom_addr, we, be, 32'h2000 + 32'(k * 4), tag | 32'(k));
            end
            h_addr = addr;
            h_data = wdata;
          end else if (addr !== h_addr || wdata !== h_data || rom_addr !== 7'(k)) begin
            errors++;
            $display("FAIL %s stall_hold k=%0d: addr=%h wdata=%h, required addr=%h wdata=%h",
                     name, k, addr, wdata, h_addr, h_data);
          end
          gnt = (wcnt >= stall);
          if (gnt) begin
            k++;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else begin
          gnt = (stall == 0);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || req !== 1'b0 || csum !== exp_cs || k != 128) begin
          errors++;
          $display("FAIL %s completion edge %0d: done=%b cpu_rst=%b req=%b csum=%h writes=%0d, required 1 0 0 %h 128",
                   name, n, done, cpu_rst, req, csum, k, exp_cs);
        end
      end
    end
    restart = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (req !== 1'b0 || addr !== 32'h0 || wdata !== 32'h0 || cpu_rst !== 1'b1 ||
        done !== 1'b0 || csum !== 32'h0 || rom_addr !== 7'd0) begin
      errors++;
      $display("FAIL reset_async: req=%b addr=%h wdata=%h cpu_rst=%b done=%b csum=%h idx=%0d, required 0 0 0 1 0 0 0",
               req, addr, wdata, cpu_rst, done, csum, rom_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (req !== 1'b0 || cpu_rst !== 1'b1 || done !== 1'b0 || req1 !== 1'b0 || cpu_rst1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: req=%b cpu_rst=%b done=%b req1=%b cpu_rst1=%b, required 0 1 0 0 1",
               req, cpu_rst, done, req1, cpu_rst1);
    end
  endtask

  task automatic test_zero_wait;
    set_rom(32'hA500_0000);
    @(negedge clk);
    rst = 1'b0;
    run_copy(0, 32'hA500_0000, 256, -1, "zero_wait");
  endtask

  task automatic test_restart;
    @(negedge clk);
    set_rom(32'h5A00_0000);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL done_hold: done=%b cpu_rst=%b, required 1 0", done, cpu_rst);
    end
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || csum !== 32'h0 || req !== 1'b0 || rom_addr !== 7'd0) begin
      errors++;
      $display("FAIL restart_taken: cpu_rst=%b done=%b csum=%h req=%b idx=%0d, required 1 0 0 0 0",
               cpu_rst, done, csum, req, rom_addr);
    end
    run_copy(0, 32'h5A00_0000, 256, -1, "recopy");
  endtask

  task automatic test_stall;
    set_rom(32'hA500_0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_copy(3, 32'hA500_0000, 640, -1, "stall3");
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gnt = 1'b1;
    repeat (81) @(negedge clk);
    checks++;
    if (req !== 1'b1 || rom_addr !== 7'd40 || addr !== 32'h0000_20A0) begin
      errors++;
      $display("FAIL abort_setup: req=%b idx=%0d addr=%h, required 1 40 000020a0", req, rom_addr, addr);
    end
    gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (req !== 1'b0 || addr !== 32'h0 || wdata !== 32'h0 || cpu_rst !== 1'b1 ||
        done !== 1'b0 || csum !== 32'h0 || rom_addr !== 7'd0) begin
      errors++;
      $display("FAIL abort_async: req=%b addr=%h wdata=%h cpu_rst=%b done=%b csum=%h idx=%0d, required 0 0 0 1 0 0 0",
               req, addr, wdata, cpu_rst, done, csum, rom_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    run_copy(0, 32'hA500_0000, 256, -1, "after_abort");
  endtask

  task automatic test_restart_ignored;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_copy(0, 32'hA500_0000, 256, 20, "restart_ignored");
  endtask

  task automatic test_words_one;
    @(negedge clk);
    rst1 = 1'b0;
    gnt1 = 1'b1;
    checks++;
    if (req1 !== 1'b0 || done1 !== 1'b0 || cpu_rst1 !== 1'b1) begin
      errors++;
      $display("FAIL one_start: req=%b done=%b cpu_rst=%b, required 0 0 1", req1, done1, cpu_rst1);
    end
    @(negedge clk);
    checks++;
    if (req1 !== 1'b1 || addr1 !== 32'h0000_4000 || wdata1 !== 32'h0001_0067 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL one_write: req=%b addr=%h wdata=%h done=%b, required 1 00004000 00010067 0",
               req1, addr1, wdata1, done1);
    end
    @(negedge clk);
    checks++;
    if (done1 !== 1'b1 || cpu_rst1 !== 1'b0 || csum1 !== 32'h0001_0067 || req1 !== 1'b0) begin
      errors++;
      $display("FAIL one_done: done=%b cpu_rst=%b csum=%h req=%b, required 1 0 00010067 0",
               done1, cpu_rst1, csum1, req1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (req1 !== 1'b0 || done1 !== 1'b1 || rom_addr1 !== 7'd0) begin
      errors++;
      $display("FAIL one_quiet: req=%b done=%b idx=%0d, required 0 1 0", req1, done1, rom_addr1);
    end
  endtask

  initial begin
    rst      = 1'b0;
    rst1     = 1'b0;
    gnt      = 1'b0;
    gnt1     = 1'b0;
    restart  = 1'b0;
    restart1 = 1'b0;
    set_rom(32'hA500_0000);
    #1;
    rst  = 1'b1;
    rst1 = 1'b1;
    test_reset;
    test_zero_wait;
    test_restart;
    test_stall;
    test_reset_abort;
    test_restart_ignored;
    test_words_one;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
